// File: rtl/traffic_light_controller_if.sv
// Controller-to-renderer bundle: control inputs, 12 lamp outputs, time_left and phase.
// EW_SENSOR_EN adds the ew_car request input.
interface traffic_light_controller_if;
  logic       hold;
  logic       force_red;
`ifdef EW_SENSOR_EN
  logic       ew_car;
`endif
  logic       N_red, N_yellow, N_green;
  logic       E_red, E_yellow, E_green;
  logic       S_red, S_yellow, S_green;
  logic       W_red, W_yellow, W_green;
  logic [7:0] time_left;
  logic [2:0] phase;

  modport master (
    input  hold, force_red,
`ifdef EW_SENSOR_EN
    input  ew_car,
`endif
    output N_red, N_yellow, N_green,
    output E_red, E_yellow, E_green,
    output S_red, S_yellow, S_green,
    output W_red, W_yellow, W_green,
    output time_left, phase
  );

  modport slave (
    output hold, force_red,
`ifdef EW_SENSOR_EN
    output ew_car,
`endif
    input  N_red, N_yellow, N_green,
    input  E_red, E_yellow, E_green,
    input  S_red, S_yellow, S_green,
    input  W_red, W_yellow, W_green,
    input  time_left, phase
  );
endinterface

// File: rtl/traffic_light_controller.sv
// Four-way traffic light controller: seconds prescaler, phase FSM with hold/force-red.
// Optional EW_SENSOR_EN: NS green extends until an east/west car is reported.
module traffic_light_controller #(
  parameter int unsigned TICK_DIV = 25000000,
  parameter int unsigned T_GREEN  = 10,
  parameter int unsigned T_YELLOW = 3,
  parameter int unsigned T_ALLRED = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  traffic_light_controller_if.master    tl_bus
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TL_W  = 8;
  localparam int unsigned LMP_W = 12;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5,
    FORCED    = 3'd6
  } state_t;

  // Per-direction lamp triplets {red, yellow, green}
  localparam logic [2:0] LMP_R = 3'b100;
  localparam logic [2:0] LMP_Y = 3'b010;
  localparam logic [2:0] LMP_G = 3'b001;

  function automatic logic [TL_W-1:0] dur_m1(input state_t s);
    logic [TL_W-1:0] d;
    case (s)
      NS_GREEN, EW_GREEN:   d = TL_W'(T_GREEN - 1);
      NS_YELLOW, EW_YELLOW: d = TL_W'(T_YELLOW - 1);
      default:              d = TL_W'(T_ALLRED - 1);
    endcase
    return d;
  endfunction

  function automatic state_t seq_next(input state_t s);
    state_t n;
    case (s)
      ALLRED_B:  n = NS_GREEN;
      NS_GREEN:  n = NS_YELLOW;
      NS_YELLOW: n = ALLRED_A;
      ALLRED_A:  n = EW_GREEN;
      EW_GREEN:  n = EW_YELLOW;
      EW_YELLOW: n = ALLRED_B;
      default:   n = ALLRED_B;
    endcase
    return n;
  endfunction

  // Lamp vector order: {N, E, S, W}, each {red, yellow, green}
  function automatic logic [LMP_W-1:0] lamp_decode(input state_t s);
    logic [2:0] ns;
    logic [2:0] ew;
    ns = LMP_R;
    ew = LMP_R;
    case (s)
      NS_GREEN:  ns = LMP_G;
      NS_YELLOW: ns = LMP_Y;
      EW_GREEN:  ew = LMP_G;
      EW_YELLOW: ew = LMP_Y;
      default:   ;
    endcase
    return {ns, ew, ns, ew};
  endfunction

  state_t             r_state;
  logic [TL_W-1:0]    r_time_left;
  logic [CNT_W-1:0]   r_tick_cnt;
  logic [LMP_W-1:0]   r_lamps;

  state_t             w_state_nxt;
  logic [TL_W-1:0]    w_time_left_nxt;
  logic [CNT_W-1:0]   w_tick_cnt_nxt;
  logic               w_tick;
  logic               w_sensor_wait;

`ifdef EW_SENSOR_EN
  assign w_sensor_wait = (r_state == NS_GREEN) && !tl_bus.ew_car;
`else
  assign w_sensor_wait = 1'b0;
`endif

  assign w_tick = (r_tick_cnt == CNT_LAST) && !tl_bus.hold && !tl_bus.force_red;

  // Next-state / timer / prescaler; priority force_red > hold > tick.
  // Leaving FORCED happens on the first low force_red cycle even under hold,
  // and the prescaler restarts from 0 so ALLRED_B gets a full clearance tick.
  always_comb begin
    w_state_nxt     = r_state;
    w_time_left_nxt = r_time_left;
    w_tick_cnt_nxt  = r_tick_cnt;
    if (tl_bus.force_red) begin
      w_state_nxt     = FORCED;
      w_time_left_nxt = '0;
      w_tick_cnt_nxt  = '0;
    end else if (r_state == FORCED) begin
      w_state_nxt     = ALLRED_B;
      w_time_left_nxt = dur_m1(ALLRED_B);
      w_tick_cnt_nxt  = '0;
    end else if (!tl_bus.hold) begin
      if (w_tick) begin
        w_tick_cnt_nxt = '0;
        if (r_time_left != '0) begin
          w_time_left_nxt = r_time_left - TL_W'(1);
        end else if (!w_sensor_wait) begin
          w_state_nxt     = seq_next(r_state);
          w_time_left_nxt = dur_m1(seq_next(r_state));
        end
      end else begin
        w_tick_cnt_nxt = r_tick_cnt + CNT_W'(1);
      end
    end
  end

  // State, timer, prescaler and registered lamp outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ALLRED_B;
      r_time_left <= TL_W'(T_ALLRED - 1);
      r_tick_cnt  <= '0;
      r_lamps     <= {LMP_R, LMP_R, LMP_R, LMP_R};
    end else begin
      r_state     <= w_state_nxt;
      r_time_left <= w_time_left_nxt;
      r_tick_cnt  <= w_tick_cnt_nxt;
      r_lamps     <= lamp_decode(w_state_nxt);
    end
  end

  assign {tl_bus.N_red, tl_bus.N_yellow, tl_bus.N_green} = r_lamps[11:9];
  assign {tl_bus.E_red, tl_bus.E_yellow, tl_bus.E_green} = r_lamps[8:6];
  assign {tl_bus.S_red, tl_bus.S_yellow, tl_bus.S_green} = r_lamps[5:3];
  assign {tl_bus.W_red, tl_bus.W_yellow, tl_bus.W_green} = r_lamps[2:0];
  assign tl_bus.time_left = r_time_left;
  assign tl_bus.phase     = r_state;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Randomized bench for traffic_light_controller against a duration-table reference model.
module tb_traffic_light_controller;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned T_GREEN  = 3;
  localparam int unsigned T_YELLOW = 1;
  localparam int unsigned T_ALLRED = 1;

  localparam int DUR [6] = '{T_GREEN, T_YELLOW, T_ALLRED, T_GREEN, T_YELLOW, T_ALLRED};

  logic clk = 1'b0;
  logic rst_n;
  logic hold_v;
  logic force_v;
`ifdef EW_SENSOR_EN
  logic car_v;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase index into the cycle (6 = forced), ticks remaining, cycles into tick
  int m_p;
  int m_left;
  int m_cnt;

  traffic_light_controller_if tl_if ();

  assign tl_if.hold      = hold_v;
  assign tl_if.force_red = force_v;
`ifdef EW_SENSOR_EN
  assign tl_if.ew_car    = car_v;
`endif

  traffic_light_controller #(
    .TICK_DIV (TICK_DIV),
    .T_GREEN  (T_GREEN),
    .T_YELLOW (T_YELLOW),
    .T_ALLRED (T_ALLRED)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .tl_bus (tl_if.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] obs_lamps();
    return {tl_if.N_red, tl_if.N_yellow, tl_if.N_green,
            tl_if.E_red, tl_if.E_yellow, tl_if.E_green,
            tl_if.S_red, tl_if.S_yellow, tl_if.S_green,
            tl_if.W_red, tl_if.W_yellow, tl_if.W_green};
  endfunction

  function automatic logic [11:0] exp_lamps(input int p);
    logic [2:0] ns;
    logic [2:0] ew;
    ns = (p == 0) ? 3'b001 : (p == 1) ? 3'b010 : 3'b100;
    ew = (p == 3) ? 3'b001 : (p == 4) ? 3'b010 : 3'b100;
    return {ns, ew, ns, ew};
  endfunction

  task automatic model_reset();
    m_p    = 5;
    m_left = DUR[5];
    m_cnt  = 0;
  endtask

  task automatic model_step();
    logic wait_car;
    wait_car = 1'b0;
`ifdef EW_SENSOR_EN
    wait_car = (m_p == 0) && !car_v;
`endif
    if (force_v) begin
      m_p = 6; m_left = 1; m_cnt = 0;
    end else if (m_p == 6) begin
      m_p = 5; m_left = DUR[5]; m_cnt = 0;
    end else if (!hold_v) begin
      if (m_cnt == int'(TICK_DIV) - 1) begin
        m_cnt = 0;
        if (m_left > 1) m_left--;
        else if (!wait_car) begin
          m_p    = (m_p + 1) % 6;
          m_left = DUR[m_p];
        end
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic check_all();
    logic [11:0] l;
    l = obs_lamps();
    chk("lamps", 32'(l), 32'(exp_lamps(m_p)));
    chk("phase", 32'(tl_if.phase), 32'(m_p));
    chk("time_left", 32'(tl_if.time_left), 32'(m_left - 1));
    chk("onehot_N", $countones(l[11:9]), 1);
    chk("onehot_E", $countones(l[8:6]), 1);
    chk("onehot_S", $countones(l[5:3]), 1);
    chk("onehot_W", $countones(l[2:0]), 1);
    chk("conflict", 32'((l[10] | l[9]) & (l[7] | l[6])), 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  // Advance until the model reaches the requested phase/remaining; expiry counts as a miscompare
  task automatic run_until(input int p, input int left, input int budget);
    int k;
    k = 0;
    while (!(m_p == p && (left == 0 || m_left == left)) && k < budget) begin
      step();
      k++;
    end
    if (k >= budget) chk("timeout", 0, 1);
  endtask

  initial begin
    rst_n   = 1'b0;
    hold_v  = 1'b0;
    force_v = 1'b0;
`ifdef EW_SENSOR_EN
    car_v   = 1'b1;
`endif
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_phase", 32'(tl_if.phase), 5);
    chk("rst_time_left", 32'(tl_if.time_left), 0);
    chk("rst_lamps", 32'(obs_lamps()), 32'h924);
    rst_n = 1'b1;

    // Nominal sequence timing from reset release
    for (int e = 1; e <= 44; e++) begin
      step();
      if (e == 3)  chk("e3_allred", 32'(tl_if.phase), 5);
      if (e == 4)  chk("e4_ns_green", 32'(tl_if.phase), 0);
      if (e == 4)  chk("e4_tl", 32'(tl_if.time_left), 2);
      if (e == 8)  chk("e8_tl", 32'(tl_if.time_left), 1);
      if (e == 12) chk("e12_tl", 32'(tl_if.time_left), 0);
      if (e == 16) chk("e16_ns_yellow", 32'(tl_if.phase), 1);
      if (e == 20) chk("e20_allred_a", 32'(tl_if.phase), 2);
      if (e == 24) chk("e24_ew_green", 32'(tl_if.phase), 3);
      if (e == 44) chk("e44_period", 32'(tl_if.phase), 0);
    end

    // Hold mid NS_GREEN with time_left=1
    run_until(0, 2, 200);
    hold_v = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_tl", 32'(tl_if.time_left), 1);
      chk("hold_phase", 32'(tl_if.phase), 0);
    end
    hold_v = 1'b0;

    // Force-red pulse during EW_YELLOW
    run_until(4, 0, 200);
    force_v = 1'b1;
    step();
    chk("force_phase", 32'(tl_if.phase), 6);
    chk("force_lamps", 32'(obs_lamps()), 32'h924);
    step();
    step();
    force_v = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("clear_allred_b", 32'(tl_if.phase), 5);
    end
    step();
    chk("clear_ns_green", 32'(tl_if.phase), 0);

    // Asynchronous reset mid EW_GREEN
    run_until(3, 0, 200);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_phase", 32'(tl_if.phase), 5);
    chk("async_rst_tl", 32'(tl_if.time_left), 0);
    chk("async_rst_lamps", 32'(obs_lamps()), 32'h924);
    model_reset();
    #1 rst_n = 1'b1;

`ifdef EW_SENSOR_EN
    // Sensor: NS green persists without an east/west car
    car_v = 1'b0;
    run_until(0, 1, 200);
    for (int i = 0; i < 100; i++) begin
      step();
      chk("sensor_wait", 32'(tl_if.phase), 0);
    end
    car_v = 1'b1;
    run_until(1, 0, 2 * TICK_DIV);
    chk("sensor_go", 32'(tl_if.phase), 1);
`endif

    // Randomized hold / force_red / sensor traffic
    for (int i = 0; i < 3000; i++) begin
      hold_v = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 39) == 0) force_v = ~force_v;
`ifdef EW_SENSOR_EN
      car_v = ($urandom_range(0, 3) == 0);
`endif
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
